muldiv_hilo_unit: RTL and testbench

- Execute-stage multiply/divide responder with HI/LO register file. It is the target that the E-stage operation issue drives.
- It accepts one operation per start pulse, iterates for a fixed latency, then commits the result to HI/LO.
- It exports busy and stall_req so the hazard unit can freeze D/E for mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.

---
 rtl/muldiv_hilo_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and fixed-latency commit.
// Define MULTDIV_MADD_EN to add MADD/MADDU (ops 6/7) multiply-accumulate into HI/LO.
module muldiv_hilo_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULTDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d;
  logic [DW-1:0]   hi_d, lo_d;
  logic [2*DW-1:0] stage_q, stage_d;
  logic            wr_q, wr_d;
`ifdef MULTDIV_MADD_EN
  logic            acc_q, acc_d;
`endif

  // Behavioural datapath: products and sign-magnitude division of the live operands.
  logic [2*DW-1:0] prod_s, prod_u;
  logic            div_zero;
  logic [DW-1:0]   mag_a, mag_b, uq, ur, quo_s, rem_s, divu_b, quo_u, rem_u;

  assign prod_s   = {{DW{src_a[DW-1]}}, src_a} * {{DW{src_b[DW-1]}}, src_b};
  assign prod_u   = {{DW{1'b0}}, src_a} * {{DW{1'b0}}, src_b};
  assign div_zero = (src_b == '0);
  assign mag_a    = src_a[DW-1] ? DW'(-src_a) : src_a;
  assign mag_b    = div_zero ? DW'(1) : (src_b[DW-1] ? DW'(-src_b) : src_b);
  assign uq       = mag_a / mag_b;
  assign ur       = mag_a % mag_b;
  assign quo_s    = (src_a[DW-1] ^ src_b[DW-1]) ? DW'(-uq) : uq;
  assign rem_s    = src_a[DW-1] ? DW'(-ur) : ur;
  assign divu_b   = div_zero ? DW'(1) : src_b;
  assign quo_u    = src_a / divu_b;
  assign rem_u    = src_a % divu_b;

  assign stall_req = start | busy;

  // State, counter, staging and HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      stage_q <= '0;
      wr_q    <= 1'b0;
`ifdef MULTDIV_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      hi      <= hi_d;
      lo      <= lo_d;
      stage_q <= stage_d;
      wr_q    <= wr_d;
`ifdef MULTDIV_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state: accept in IDLE, count down in RUN, commit staged result on the last edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    hi_d    = hi;
    lo_d    = lo;
    stage_d = stage_q;
    wr_d    = wr_q;
`ifdef MULTDIV_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d = RUN;
              cnt_d   = MULT_N;
              busy_d  = 1'b1;
              wr_d    = 1'b1;
              stage_d = (op == OP_MULT) ? prod_s : prod_u;
`ifdef MULTDIV_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              state_d = RUN;
              cnt_d   = DIV_N;
              busy_d  = 1'b1;
              wr_d    = ~div_zero;
              stage_d = (op == OP_DIV) ? {rem_s, quo_s} : {rem_u, quo_u};
`ifdef MULTDIV_MADD_EN
              acc_d   = 1'b0;
`endif
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
`ifdef MULTDIV_MADD_EN
            OP_MADD, OP_MADDU: begin
              state_d = RUN;
              cnt_d   = MULT_N;
              busy_d  = 1'b1;
              wr_d    = 1'b1;
              stage_d = (op == OP_MADD) ? prod_s : prod_u;
              acc_d   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef MULTDIV_MADD_EN
          if (wr_q) {hi_d, lo_d} = acc_q ? ({hi, lo} + stage_q) : stage_q;
`else
          if (wr_q) {hi_d, lo_d} = stage_q;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit: arithmetic reference model, queued expectations,
// monitor checking busy/stall_req every cycle and HI/LO/latency on each done pulse.
module tb_muldiv_hilo_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  muldiv_hilo_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] hl;
    int          at;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_first = 0;
  int          busy_last = -1;
  logic [31:0] mhi = '0, mlo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit exp_busy(int c);
    return (c >= busy_first) && (c <= busy_last);
  endfunction

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: control outputs every cycle, results and timing on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    chk("busy", 64'(busy), 64'(exp_busy(cyc)));
    chk("stall_req", 64'(stall_req), 64'(start | exp_busy(cyc)));
    if (done) begin
      if (sbq.size() == 0) begin
        chk("done_spurious", 64'(done), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.at));
        chk("result_hilo", {hi, lo}, e.hl);
      end
    end else if (sbq.size() > 0 && sbq[0].at < cyc) begin
      e = sbq.pop_front();
      chk("done_missing", 64'(done), 64'd1);
    end
  end

  // Issue one instruction; the model decides whether the DUT accepts it.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     res;
    int              n;
    exp_t            e;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (exp_busy(cyc)) return;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = {32'h0, a};           ub = {32'h0, b};
    res = {mhi, mlo};
    n = 0;
    case (o)
      3'd0: begin res = sa * sb; n = MC; end
      3'd1: begin res = ua * ub; n = MC; end
      3'd2: begin
        n = DC;
        if (b != 0) res = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        n = DC;
        if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: mhi = a;
      3'd5: mlo = a;
`ifdef MULTDIV_MADD_EN
      3'd6: begin res = {mhi, mlo} + 64'(sa * sb); n = MC; end
      3'd7: begin res = {mhi, mlo} + 64'(ua * ub); n = MC; end
`endif
      default: ;
    endcase
    if (n > 0) begin
      busy_first = cyc + 1;
      busy_last  = cyc + n;
      e.hl = res;
      e.at = cyc + n + 1;
      sbq.push_back(e);
      {mhi, mlo} = res;
    end
  endtask

  // One cycle with start low; operands scrambled to prove they were latched.
  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_idle();
    int i;
    idle();
    for (i = 0; i < 64 && (exp_busy(cyc) || sbq.size() != 0); i++) idle();
    if (i == 64) chk("wait_idle_timeout", 64'd1, 64'd0);
    chk("hilo_model", {hi, lo}, {mhi, mlo});
  endtask

  task automatic check_const(string name, logic [63:0] exp);
    chk(name, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    idle();

    issue(3'd0, 32'hFFFF_FFFE, 32'h3); wait_idle();
    check_const("mult_neg", 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'h3); wait_idle();
    check_const("multu", 64'h0000_0002_FFFF_FFFA);
    issue(3'd2, 32'hFFFF_FFF9, 32'h2); wait_idle();
    check_const("div_neg", 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'd3, 32'h7, 32'h2); wait_idle();
    check_const("divu", 64'h0000_0001_0000_0003);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    check_const("div_ovf", 64'h0000_0000_8000_0000);
    issue(3'd4, 32'h11, 32'h0); issue(3'd5, 32'h22, 32'h0); idle();
    issue(3'd3, 32'h5, 32'h0); wait_idle();
    check_const("divu_zero", 64'h0000_0011_0000_0022);

    issue(3'd4, 32'hABCD_0000, 32'h0); issue(3'd5, 32'h1234, 32'h0); wait_idle();
    check_const("mthi_mtlo", 64'hABCD_0000_0000_1234);

    issue(3'd0, 32'd6, 32'd7); idle(); idle();
    issue(3'd0, 32'd100, 32'd100); wait_idle();
    check_const("start_ignored", 64'h0000_0000_0000_002A);

    issue(3'd4, 32'h0, 32'h0); issue(3'd5, 32'hFFFF_FFFF, 32'h0); idle();
    issue(3'd7, 32'h1, 32'h1); wait_idle();
`ifdef MULTDIV_MADD_EN
    check_const("maddu", 64'h0000_0001_0000_0000);
`else
    check_const("maddu_noop", 64'h0000_0000_FFFF_FFFF);
`endif

    // Reset on the second busy cycle of a MULT discards it.
    issue(3'd0, 32'd3, 32'd4); idle();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sbq.delete(); busy_first = 0; busy_last = -1; mhi = '0; mlo = '0;
    #1;
    chk("midrun_reset_hilo", {hi, lo}, 64'd0);
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) idle();
    check_const("after_reset", 64'd0);

    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
      repeat ($urandom_range(0, 12)) idle();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
